// File: rtl/ball_hit_detector.sv
// Per-frame ball collision detector: accumulates shot/ball and player/ball overlap
// over one video frame and reports hits at the next frame boundary. Optional macro: INVULN_EN.
module ball_hit_detector #(
    parameter int MIN_OVERLAP   = 4,
    parameter int INVULN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        ballRequest,
    input  logic        shotRequest,
    input  logic        playerRequest,
    output logic        shotHitPulse,
    output logic [10:0] hitX,
    output logic [10:0] hitY,
    output logic        playerHitPulse,
    output logic        invulnerable
);

    typedef enum logic {
        WAIT_FRAME,
        COLLECT
    } state_t;

    state_t      state, state_n;
    logic        report;
    logic        shotSeen, shotSeen_n;
    logic [10:0] capX, capX_n, capY, capY_n;
    logic [3:0]  playerCnt, playerCnt_n;
    logic        ovShot, ovPlayer, playerReady, playerFlag;

    assign ovShot      = ballRequest && shotRequest;
    assign ovPlayer    = ballRequest && playerRequest;
    assign playerReady = (playerCnt >= 4'(MIN_OVERLAP));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= WAIT_FRAME;
        else       state <= state_n;
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
        state_n = state;
        report  = 1'b0;
        case (state)
            WAIT_FRAME: if (startOfFrame) state_n = COLLECT;
            COLLECT:    report = startOfFrame;
            default:    state_n = WAIT_FRAME;
        endcase
    end

    // The startOfFrame pixel is applied after the clear, so it belongs to the new frame.
    always_comb begin
        shotSeen_n  = shotSeen;
        capX_n      = capX;
        capY_n      = capY;
        playerCnt_n = playerCnt;
        if (startOfFrame) begin
            shotSeen_n  = 1'b0;
            playerCnt_n = 4'd0;
        end
        if (state == COLLECT || startOfFrame) begin
            if (ovShot && !shotSeen_n) begin
                shotSeen_n = 1'b1;
                capX_n     = pixelX;
                capY_n     = pixelY;
            end
            if (ovPlayer && playerCnt_n != 4'd15)
                playerCnt_n = playerCnt_n + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shotSeen  <= 1'b0;
            capX      <= '0;
            capY      <= '0;
            playerCnt <= '0;
        end else begin
            shotSeen  <= shotSeen_n;
            capX      <= capX_n;
            capY      <= capY_n;
            playerCnt <= playerCnt_n;
        end
    end

`ifdef INVULN_EN
    logic [7:0] invulnCnt, invulnDec;

    // Frame boundary decrements first, so the closing frame sees the post-decrement value.
    assign invulnDec    = (report && invulnCnt != 8'd0) ? invulnCnt - 8'd1 : invulnCnt;
    assign playerFlag   = report && playerReady && (invulnDec == 8'd0);
    assign invulnerable = (invulnCnt != 8'd0);

    always_ff @(posedge clk) begin
        if (reset)               invulnCnt <= 8'd0;
        else if (playerHitPulse) invulnCnt <= 8'(INVULN_FRAMES);
        else                     invulnCnt <= invulnDec;
    end
`else
    assign playerFlag   = report && playerReady;
    assign invulnerable = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            shotHitPulse   <= 1'b0;
            playerHitPulse <= 1'b0;
            hitX           <= '0;
            hitY           <= '0;
        end else begin
            shotHitPulse   <= report && shotSeen;
            playerHitPulse <= playerFlag;
            if (report && shotSeen) begin
                hitX <= capX;
                hitY <= capY;
            end
        end
    end

endmodule

// File: tb/tb_ball_hit_detector.sv
// Randomized and directed bench for ball_hit_detector against a frame-level reference model.
// Honours INVULN_EN when defined for the build.
module tb_ball_hit_detector;

    localparam int MIN_OV = 4;
    localparam int INV_N  = 2;

    logic        clk = 1'b0;
    logic        reset, startOfFrame, ballRequest, shotRequest, playerRequest;
    logic [10:0] pixelX, pixelY;
    logic        shotHitPulse, playerHitPulse, invulnerable;
    logic [10:0] hitX, hitY;

    always #5 clk = ~clk;

    ball_hit_detector #(.MIN_OVERLAP(MIN_OV), .INVULN_FRAMES(INV_N)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY),
        .ballRequest(ballRequest), .shotRequest(shotRequest), .playerRequest(playerRequest),
        .shotHitPulse(shotHitPulse), .hitX(hitX), .hitY(hitY),
        .playerHitPulse(playerHitPulse), .invulnerable(invulnerable)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference model: a frame is a list of shot overlap points plus a player overlap count.
    bit m_started;
    int m_cnt;
    int m_qx[$];
    int m_qy[$];
    int m_inv;
    bit e_shot, e_player;
    int e_hx, e_hy;
    int cur_x, cur_y;

    task automatic step(input bit rst, input bit sof, input int x, input int y,
                        input bit b, input bit s, input bit p);
        bit load;
        @(negedge clk);
        reset = rst; startOfFrame = sof; pixelX = 11'(x); pixelY = 11'(y);
        ballRequest = b; shotRequest = s; playerRequest = p;
        @(posedge clk);
        #1;
        if (rst) begin
            m_started = 0; m_cnt = 0; m_qx.delete(); m_qy.delete(); m_inv = 0;
            e_shot = 0; e_player = 0; e_hx = 0; e_hy = 0;
        end else begin
            load = e_player;
            e_shot = 0;
            e_player = 0;
            if (m_started && sof) begin
`ifdef INVULN_EN
                if (m_inv > 0) m_inv--;
`endif
                if (m_qx.size() > 0) begin
                    e_shot = 1; e_hx = m_qx[0]; e_hy = m_qy[0];
                end
                e_player = (m_cnt >= MIN_OV) && (m_inv == 0);
                m_qx.delete(); m_qy.delete(); m_cnt = 0;
            end
`ifdef INVULN_EN
            if (load) m_inv = INV_N;
`endif
            if (sof) m_started = 1;
            if (m_started) begin
                if (b && s) begin m_qx.push_back(x % 2048); m_qy.push_back(y % 2048); end
                if (b && p) m_cnt++;
            end
        end
        check("shotHitPulse", 32'(shotHitPulse), 32'(e_shot));
        check("playerHitPulse", 32'(playerHitPulse), 32'(e_player));
        check("hitX", 32'(hitX), 32'(e_hx));
        check("hitY", 32'(hitY), 32'(e_hy));
        check("invulnerable", 32'(invulnerable), 32'(m_inv != 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, i, 5, 0, 0, 0);
    endtask

    task automatic sof_empty();
        step(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic player_frame(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 300 + i, 40, 1, 0, 1);
        idle(2);
    endtask

    initial begin
        int pulses;
        // Reset state
        do_reset();
        check("reset_shot", 32'(shotHitPulse), 0);
        check("reset_hitX", 32'(hitX), 0);
        check("reset_player", 32'(playerHitPulse), 0);

        // First shot overlap is captured, later ones ignored, held through an empty frame
        sof_empty();
        idle(3);
        step(0, 0, 100, 200, 1, 1, 0);
        step(0, 0, 101, 200, 1, 1, 0);
        idle(3);
        sof_empty();
        check("t1_pulse", 32'(shotHitPulse), 1);
        check("t1_hitX", 32'(hitX), 100);
        check("t1_hitY", 32'(hitY), 200);
        idle(1);
        check("t1_width", 32'(shotHitPulse), 0);
        idle(4);
        sof_empty();
        check("t1_empty", 32'(shotHitPulse), 0);
        check("t1_holdX", 32'(hitX), 100);
        check("t1_holdY", 32'(hitY), 200);

        // Partial frame after reset is discarded
        do_reset();
        step(0, 0, 50, 60, 1, 1, 1);
        step(0, 0, 51, 60, 1, 1, 1);
        sof_empty();
        check("t2_first", 32'(shotHitPulse), 0);
        idle(3);
        sof_empty();
        check("t2_second", 32'(shotHitPulse), 0);

        // Player threshold: 3 below, 4 at threshold
        idle(2);
        player_frame(3);
        sof_empty();
        check("t3_three", 32'(playerHitPulse), 0);
        player_frame(4);
        sof_empty();
        check("t3_four", 32'(playerHitPulse), 1);
        idle(2);

        // Both hits in one frame (fresh reset so invulnerability cannot interfere)
        do_reset();
        sof_empty();
        step(0, 0, 7, 9, 1, 1, 0);
        player_frame(5);
        sof_empty();
        check("t4_shot", 32'(shotHitPulse), 1);
        check("t4_player", 32'(playerHitPulse), 1);

`ifdef INVULN_EN
        // Invulnerability window of two frame boundaries
        do_reset();
        sof_empty();
        pulses = 0;
        for (int f = 0; f < 4; f++) begin
            player_frame(5);
            sof_empty();
            check("t5_pulse", 32'(playerHitPulse), 32'((f % 2) == 0));
            pulses += int'(playerHitPulse);
            idle(1);
            if (f % 2 == 0) check("t5_invuln", 32'(invulnerable), 1);
        end
        check("t5_count", 32'(pulses), 2);
`else
        pulses = 0;
`endif

        // Reset mid-frame drops the pending report
        do_reset();
        sof_empty();
        step(0, 0, 20, 30, 1, 1, 1);
        player_frame(6);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        sof_empty();
        check("t6_shot1", 32'(shotHitPulse), 0);
        idle(3);
        sof_empty();
        check("t6_shot2", 32'(shotHitPulse), 0);
        check("t6_player", 32'(playerHitPulse), 0);
        check("t6_hitX", 32'(hitX), 0);
        check("t6_invuln", 32'(invulnerable), 0);
        idle(3);
        sof_empty();
        check("t6_shot3", 32'(shotHitPulse), 0);

        // Randomized frames: variable length, density, occasional resets and back-to-back starts
        for (int f = 0; f < 400; f++) begin
            int len, dens;
            if ($urandom_range(0, 24) == 0) step(1, 0, 0, 0, 0, 0, 0);
            len  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
            dens = int'($urandom_range(0, 3));
            cur_y = int'($urandom_range(0, 2047));
            step(0, 1, int'($urandom_range(0, 2047)), cur_y,
                 dens != 0 && $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0);
            for (int i = 0; i < len; i++) begin
                bit b, s, p;
                cur_x = int'($urandom_range(0, 2047));
                b = (dens != 0) && ($urandom_range(0, 3) < dens);
                s = ($urandom_range(0, 9) == 0);
                p = ($urandom_range(0, 3) == 0);
                step(0, 0, cur_x, cur_y, b, s, p);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_hit_detector.md
# ball_hit_detector

Per-frame collision detector downstream of the ball priority mux. Each pixel cycle it compares the mux's combined ball request against the shot and player requests. It accumulates overlap over one video frame, then issues at most one shot-hit pulse and one player-hit pulse at each frame boundary. The first shot/ball overlap coordinate is reported so game logic can pick the ball to split.

## Interface
- MIN_OVERLAP, 4: overlapping ball/player pixels per frame needed for a player hit (1..15)
- INVULN_FRAMES, 60: frames of player invulnerability after a player hit (1..255; used only with INVULN_EN)
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse on the first pixel of each frame
- pixelX  in  11  current pixel column
- pixelY  in  11  current pixel row
- ballRequest  in  1  any ball drawn at this pixel (OR of all ball requests)
- shotRequest  in  1  shot (rope) drawn at this pixel
- playerRequest  in  1  player sprite drawn at this pixel
- shotHitPulse  out  1  one-cycle pulse: shot touched a ball last frame
- hitX  out  11  column of first shot/ball overlap of the reported frame
- hitY  out  11  row of first shot/ball overlap of the reported frame
- playerHitPulse  out  1  one-cycle pulse: player hit last frame
- invulnerable  out  1  high while player hits are suppressed

## Operation
- All request inputs refer to the same pixel (pixelX, pixelY) in the same cycle. No input registering.
- FSM states:
  - WAIT_FRAME: entered on reset. Ignores all overlap until the first startOfFrame, so a partial frame is discarded. Moves to COLLECT on startOfFrame.
  - COLLECT: stays in COLLECT. On every startOfFrame it performs the frame report.
- Working registers, cleared at the frame report:
  - shotSeen: set on the first cycle with ballRequest && shotRequest. On that cycle pixelX/pixelY are captured into capX/capY. Later overlaps in the same frame do not recapture.
  - playerCnt: 4-bit count of cycles with ballRequest && playerRequest. Saturates at 15.
- Frame report on a startOfFrame cycle in COLLECT:
  - Snapshot shotSeen, capX, capY and (playerCnt >= MIN_OVERLAP).
  - Clear the working registers.
  - The startOfFrame pixel itself counts toward the new frame, applied after the clear.
- One cycle after the report:
  - shotHitPulse = snapshot shotSeen. When it is 1, hitX/hitY load capX/capY in the same cycle.
  - playerHitPulse = snapshot player flag && !invulnerable.
- hitX/hitY hold their value until the next shotHitPulse.
- Both hits in one frame: both pulses are asserted in the same cycle.
- Reset values: shotHitPulse=0, playerHitPulse=0, hitX=0, hitY=0, invulnerable=0, playerCnt=0, shotSeen=0, state=WAIT_FRAME.

## Timing
- Pulse latency: one clock after the startOfFrame that closes the frame. Pulse width is exactly one clock.
- Pulses are issued at most once per frame per type. They never come from WAIT_FRAME.
- startOfFrame pulses on consecutive cycles each close a frame. An empty frame produces no pulse.
- Reset asserted mid-frame: all state returns to reset values on the next edge. A pending report pulse is dropped.
- Invulnerability counter (INVULN_EN only), 8 bits:
  - Loaded with INVULN_FRAMES on the cycle playerHitPulse is asserted.
  - Decremented on each later startOfFrame. The decrement happens before that frame's report is evaluated.
  - invulnerable = (counter != 0).
  - With INVULN_FRAMES=1, the very next frame can already produce a hit.

## Configuration
- INVULN_EN defined: the invulnerability counter and invulnerable output behave as above. Player overlaps in suppressed frames are counted but discarded at report.
- INVULN_EN undefined: the counter is not built and invulnerable is tied to 0. Every frame with playerCnt >= MIN_OVERLAP pulses playerHitPulse.
- Shot-hit behaviour is identical in both builds.

## Test plan
- Reset, first startOfFrame, then ball&&shot at (100,200) and at (101,200), then startOfFrame -> one cycle later shotHitPulse=1 for one clock, hitX=100, hitY=200. Both stay held through the following empty frame.
- Ball/shot overlap before the first startOfFrame after reset -> no shotHitPulse at the first or second frame boundary.
- Ball&&player for 3 cycles with MIN_OVERLAP=4 -> no playerHitPulse. Ball&&player for 4 cycles -> playerHitPulse=1 one cycle after startOfFrame.
- Shot overlap and 5 player-overlap cycles in one frame -> shotHitPulse and playerHitPulse asserted in the same cycle.
- INVULN_EN, INVULN_FRAMES=2, player hit in frames 1, 2, 3, 4 -> pulses after frames 1 and 3 only; invulnerable high for two frame boundaries after each pulse.
- Reset asserted mid-frame after an overlap, then two frames without overlap -> no pulses; all outputs 0.
